// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: issues fetch requests under a credit limit, tags in-order
// responses with their PC and queues (pc, inst) pairs for decode.
//
// state | meaning
// IDLE  | no request on the address channel
// REQ   | inst_req asserted, waiting for inst_addr_ok
// DRAIN | flushed; dropping responses still owed by memory
module inst_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pc_ce,
    input  logic [ADDR_W-1:0] i_pc_addr,
    output logic              o_pc_advance,
    input  logic              i_flush,
    output logic              o_inst_req,
    output logic [ADDR_W-1:0] o_inst_addr,
    input  logic              i_inst_addr_ok,
    input  logic [DATA_W-1:0] i_inst_rdata,
    input  logic              i_inst_data_ok,
    output logic              o_id_valid,
    output logic [ADDR_W-1:0] o_id_pc,
    output logic [DATA_W-1:0] o_id_inst,
    input  logic              i_id_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_inst_addr;
    logic [CW-1:0]     r_fifo_count;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_discard;

    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];
    logic [DATA_W-1:0] r_fifo_inst [DEPTH];
    logic [PW-1:0]     r_fifo_rd;
    logic [PW-1:0]     r_fifo_wr;

    logic [ADDR_W-1:0] r_tag_pc [DEPTH];
    logic [PW-1:0]     r_tag_rd;
    logic [PW-1:0]     r_tag_wr;

    logic              w_req;
    logic              w_accept;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_tag_push;
    logic              w_load_addr;
    logic [CW-1:0]     w_inflight_next;
    logic [CW-1:0]     w_fifo_count_next;
    logic [CW:0]       w_credits;
    logic [CW:0]       w_credits_after;
    logic              w_start;
    logic              w_continue;

    assign w_req      = (r_state == S_REQ);
    assign w_accept   = w_req & i_inst_addr_ok;
    assign w_drop     = i_inst_data_ok & (r_discard != '0);
    assign w_push     = i_inst_data_ok & (r_discard == '0) & ~i_flush;
    assign w_pop      = o_id_valid & i_id_ready & ~i_flush;
    assign w_tag_push = w_accept & ~i_flush;

    assign w_inflight_next   = r_inflight + CW'(w_accept) - CW'(i_inst_data_ok);
    assign w_fifo_count_next = r_fifo_count + CW'(w_push) - CW'(w_pop);

    // Every accepted address holds a FIFO slot until its entry is popped,
    // so a returning response can never find the FIFO full.
    assign w_credits       = {1'b0, r_fifo_count} + {1'b0, r_inflight};
    assign w_credits_after = {1'b0, w_fifo_count_next} + {1'b0, w_inflight_next};
    assign w_start         = i_pc_ce & (w_credits < LP_DEPTH);
    assign w_continue      = i_pc_ce & (w_credits_after < LP_DEPTH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = (w_inflight_next != '0) ? S_DRAIN : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_state_next = S_REQ;
                S_REQ:   if (i_inst_addr_ok && !w_continue) w_state_next = S_IDLE;
                S_DRAIN: if (i_inst_data_ok && (r_discard == CW'(1))) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_inst_req   = w_req;
        o_pc_advance = w_accept;
        w_load_addr  = 1'b0;
        if (!i_flush) begin
            case (r_state)
                S_IDLE:  w_load_addr = w_start;
                S_REQ:   w_load_addr = i_inst_addr_ok & w_continue;
                default: w_load_addr = 1'b0;
            endcase
        end
    end

    // A flush keeps counting the same-cycle accept and response in inflight;
    // everything still owed by memory becomes discard.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inst_addr  <= '0;
            r_fifo_count <= '0;
            r_inflight   <= '0;
            r_discard    <= '0;
            r_fifo_rd    <= '0;
            r_fifo_wr    <= '0;
            r_tag_rd     <= '0;
            r_tag_wr     <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (w_load_addr) r_inst_addr <= i_pc_addr;
            if (i_flush) begin
                r_fifo_count <= '0;
                r_discard    <= w_inflight_next;
                r_fifo_rd    <= '0;
                r_fifo_wr    <= '0;
                r_tag_rd     <= '0;
                r_tag_wr     <= '0;
            end else begin
                r_fifo_count <= w_fifo_count_next;
                r_discard    <= r_discard - CW'(w_drop);
                if (w_push)     r_fifo_wr <= r_fifo_wr + 1'b1;
                if (w_pop)      r_fifo_rd <= r_fifo_rd + 1'b1;
                if (w_tag_push) r_tag_wr  <= r_tag_wr + 1'b1;
                if (w_push)     r_tag_rd  <= r_tag_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_tag_push) r_tag_pc[r_tag_wr] <= r_inst_addr;
        if (w_push) begin
            r_fifo_pc[r_fifo_wr]   <= r_tag_pc[r_tag_rd];
            r_fifo_inst[r_fifo_wr] <= i_inst_rdata;
        end
    end

    assign o_inst_addr = r_inst_addr;
    assign o_id_valid  = (r_fifo_count != '0);
    assign o_id_pc     = r_fifo_pc[r_fifo_rd];
    assign o_id_inst   = r_fifo_inst[r_fifo_rd];

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: a PC generator and in-order memory drive the
// DUT while a monitor pops hand-written expected (pc, inst) pairs on each ID handshake.
module tb_inst_fetch_buffer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_pc_ce;
    logic [31:0] i_pc_addr;
    logic        o_pc_advance;
    logic        i_flush;
    logic        o_inst_req;
    logic [31:0] o_inst_addr;
    logic        i_inst_addr_ok;
    logic [31:0] i_inst_rdata;
    logic        i_inst_data_ok;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_inst;
    logic        i_id_ready;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          cyc = 0;
    int          lat = 1;
    bit          mem_en = 1'b1;
    logic [31:0] tb_pc;
    int          n_acc;
    int          limit;

    always #5 i_clk = ~i_clk;

    inst_fetch_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pc_ce        (i_pc_ce),
        .i_pc_addr      (i_pc_addr),
        .o_pc_advance   (o_pc_advance),
        .i_flush        (i_flush),
        .o_inst_req     (o_inst_req),
        .o_inst_addr    (o_inst_addr),
        .i_inst_addr_ok (i_inst_addr_ok),
        .i_inst_rdata   (i_inst_rdata),
        .i_inst_data_ok (i_inst_data_ok),
        .o_id_valid     (o_id_valid),
        .o_id_pc        (o_id_pc),
        .o_id_inst      (o_id_inst),
        .i_id_ready     (i_id_ready)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(inst);
    endfunction

    // Scoreboard monitor: a handshake in a flush cycle is ignored by the design.
    always @(negedge i_clk) begin
        if (i_rst === 1'b0 && o_id_valid === 1'b1 && i_id_ready === 1'b1 && i_flush === 1'b0) begin
            if (exp_pc_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL id_unexpected actual pc=%h inst=%h required=none", o_id_pc, o_id_inst);
            end else begin
                chk("id_pc", o_id_pc, exp_pc_q.pop_front());
                chk("id_inst", o_id_inst, exp_inst_q.pop_front());
            end
        end
    end

    // One clock: record accepts, step the PC on pc_advance, then present memory responses.
    task automatic tick();
        @(negedge i_clk);
        if (o_inst_req === 1'b1 && i_inst_addr_ok === 1'b1) begin
            mem_addr_q.push_back(o_inst_addr);
            mem_due_q.push_back(cyc + lat);
        end
        if (o_pc_advance === 1'b1) begin
            n_acc++;
            tb_pc = tb_pc + 32'd4;
            i_pc_addr = tb_pc;
            if (n_acc >= limit) i_pc_ce = 1'b0;
        end
        @(posedge i_clk);
        #1;
        cyc++;
        i_flush = 1'b0;
        if (mem_en && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            i_inst_data_ok = 1'b1;
            i_inst_rdata   = 32'hE000_0000 | mem_addr_q[0];
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            i_inst_data_ok = 1'b0;
            i_inst_rdata   = 32'h0;
        end
    endtask

    task automatic redirect(input logic [31:0] pc, input int lim);
        tb_pc     = pc;
        i_pc_addr = pc;
        n_acc     = 0;
        limit     = lim;
        i_pc_ce   = 1'b1;
    endtask

    task automatic wait_req(input string name, input int bound);
        int k;
        k = 0;
        while (o_inst_req !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        chk(name, {31'd0, o_inst_req}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 40; k++) begin
            if (exp_pc_q.size() == 0 && mem_addr_q.size() == 0 && o_id_valid === 1'b0) break;
            tick();
        end
        chk(name, exp_pc_q.size(), 32'd0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_flush = 1'b0;
        i_inst_addr_ok = 1'b1;
        i_inst_data_ok = 1'b0;
        i_inst_rdata = 32'h0;
        i_id_ready = 1'b1;
        redirect(32'h0, 3);

        // 1: reset with pc_ce high
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_inst_req", {31'd0, o_inst_req}, 32'd0);
            chk("rst_id_valid", {31'd0, o_id_valid}, 32'd0);
            chk("rst_pc_advance", {31'd0, o_pc_advance}, 32'd0);
        end
        chk("rst_inst_addr", o_inst_addr, 32'h0);
        i_rst = 1'b0;

        // 2: streaming 0x0, 0x4, 0x8
        push_exp(32'h0000_0000, 32'hE000_0000);
        push_exp(32'h0000_0004, 32'hE000_0004);
        push_exp(32'h0000_0008, 32'hE000_0008);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stream_pc_advance", {31'd0, o_pc_advance}, 32'd1);
            tick();
        end
        chk("stream_req_done", {31'd0, o_inst_req}, 32'd0);
        chk("stream_valid_c4", {31'd0, o_id_valid}, 32'd1);
        chk("stream_pc_c4", o_id_pc, 32'h0000_0004);
        tick();
        chk("stream_pc_c5", o_id_pc, 32'h0000_0008);
        tick();
        chk("stream_valid_c6", {31'd0, o_id_valid}, 32'd0);
        wait_drain("stream_drain");

        // 3: backpressure, credits exhaust after 4 accepts
        i_id_ready = 1'b0;
        push_exp(32'h0000_0040, 32'hE000_0040);
        push_exp(32'h0000_0044, 32'hE000_0044);
        push_exp(32'h0000_0048, 32'hE000_0048);
        push_exp(32'h0000_004C, 32'hE000_004C);
        push_exp(32'h0000_0050, 32'hE000_0050);
        push_exp(32'h0000_0054, 32'hE000_0054);
        redirect(32'h40, 6);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (n_acc >= 4) break;
        end
        chk("bp_accepts", n_acc, 32'd4);
        chk("bp_req_off", {31'd0, o_inst_req}, 32'd0);
        chk("bp_adv_off", {31'd0, o_pc_advance}, 32'd0);
        tick();
        chk("bp_req_still_off", {31'd0, o_inst_req}, 32'd0);
        chk("bp_head_valid", {31'd0, o_id_valid}, 32'd1);
        chk("bp_head_pc", o_id_pc, 32'h0000_0040);
        i_id_ready = 1'b1;
        wait_req("bp_resume", 10);
        chk("bp_resume_addr", o_inst_addr, 32'h0000_0050);
        wait_drain("bp_drain");

        // 4: address stall at 0x100
        i_inst_addr_ok = 1'b0;
        push_exp(32'h0000_0100, 32'hE000_0100);
        redirect(32'h100, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", {31'd0, o_inst_req}, 32'd1);
            chk("stall_addr", o_inst_addr, 32'h0000_0100);
            chk("stall_adv", {31'd0, o_pc_advance}, 32'd0);
            tick();
        end
        i_inst_addr_ok = 1'b1;
        #1;
        chk("stall_accept_adv", {31'd0, o_pc_advance}, 32'd1);
        chk("stall_accept_addr", o_inst_addr, 32'h0000_0100);
        tick();
        wait_drain("stall_drain");

        // 5: flush with a buffered entry and 2 in flight
        i_id_ready = 1'b0;
        lat = 1;
        redirect(32'h300, 3);
        tick();
        tick();
        mem_en = 1'b0;
        tick();
        tick();
        chk("fl_pre_valid", {31'd0, o_id_valid}, 32'd1);
        chk("fl_pre_pc", o_id_pc, 32'h0000_0300);
        i_flush = 1'b1;
        i_id_ready = 1'b1;
        redirect(32'h200, 1);
        push_exp(32'h0000_0200, 32'hE000_0200);
        tick();
        chk("fl_valid_cleared", {31'd0, o_id_valid}, 32'd0);
        chk("fl_req_off", {31'd0, o_inst_req}, 32'd0);
        mem_en = 1'b1;
        wait_req("fl_new_req", 20);
        chk("fl_new_addr", o_inst_addr, 32'h0000_0200);
        chk("fl_drained_first", mem_addr_q.size(), 32'd0);
        wait_drain("fl_drain");

        // 6: flush coincident with data_ok and addr_ok
        redirect(32'h400, 100);
        tick();
        tick();
        chk("co_addr", o_inst_addr, 32'h0000_0404);
        i_flush = 1'b1;
        #1;
        chk("co_flush_adv", {31'd0, o_pc_advance}, 32'd1);
        tick();
        chk("co_valid_off", {31'd0, o_id_valid}, 32'd0);
        chk("co_req_off", {31'd0, o_inst_req}, 32'd0);
        redirect(32'h500, 1);
        push_exp(32'h0000_0500, 32'hE000_0500);
        wait_req("co_new_req", 20);
        chk("co_new_addr", o_inst_addr, 32'h0000_0500);
        chk("co_drained_first", mem_addr_q.size(), 32'd0);
        wait_drain("co_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
